// File: rtl/difftest_step_batcher.sv
// Batches per-cycle commit counts into difftest step reports and converts a trap into an exit code.
// Optional build macro DIFFTEST_STEP_TIMEOUT_EN flushes a partial batch after TIMEOUT idle cycles.
module difftest_step_batcher #(
    parameter int STEP_W   = 8,
    parameter int CNT_IN_W = 4,
    parameter int BATCH    = 16,
    parameter int TIMEOUT  = 64
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic [CNT_IN_W-1:0] commit_cnt,
    input  logic                trap_valid,
    input  logic                trap_good,
    input  logic [31:0]         trap_code,
    output logic [STEP_W-1:0]   difftest_step,
    output logic [63:0]         difftest_exit,
    output logic                dropped
);

    localparam logic [STEP_W:0] MAX_V   = {1'b0, {STEP_W{1'b1}}};
    localparam logic [STEP_W:0] BATCH_V = (STEP_W+1)'(BATCH);

    if ((BATCH < 1) || (BATCH > (2**STEP_W - 1)) || (TIMEOUT < 1) || (CNT_IN_W > STEP_W)) begin : g_bad_param
        $error("difftest_step_batcher: illegal parameter combination");
    end

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_EXITED = 2'd2
    } state_t;

    function automatic logic [STEP_W-1:0] sat_step(input logic [STEP_W:0] v);
        return (v > MAX_V) ? MAX_V[STEP_W-1:0] : v[STEP_W-1:0];
    endfunction

    function automatic logic [63:0] exit_code(input logic good, input logic [31:0] code);
        if (good)
            return '1;
        // A bad trap must never look like "still running", so code 0 becomes 1.
        else if (code == 32'h0)
            return 64'd1;
        else
            return {32'h0, code};
    endfunction

    state_t              r_state;
    state_t              w_state_nxt;
    logic [STEP_W:0]     r_acc;
    logic [STEP_W:0]     w_acc_nxt;
    logic [STEP_W:0]     w_sum;
    logic [STEP_W-1:0]   r_step;
    logic [STEP_W-1:0]   w_step_nxt;
    logic [63:0]         r_exit;
    logic [63:0]         w_exit_nxt;
    logic                r_dropped;
    logic                w_dropped_nxt;
    logic                r_trap_good;
    logic [31:0]         r_trap_code;
    logic                w_capture;
    logic                w_emit_run;
    logic                w_flush;
    logic [STEP_W-1:0]   w_e_run;
    logic [STEP_W-1:0]   w_e_drain;

    assign w_sum     = r_acc + (STEP_W+1)'(commit_cnt);
    assign w_e_run   = sat_step(w_sum);
    assign w_e_drain = sat_step(r_acc);

`ifdef DIFFTEST_STEP_TIMEOUT_EN
    localparam int IDLE_W = $clog2(TIMEOUT) + 1;
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT - 1);

    logic [IDLE_W-1:0] r_idle;
    logic [IDLE_W-1:0] w_idle_nxt;

    assign w_flush = (r_idle == IDLE_LAST) && (w_sum != '0);

    // Counts RUN cycles that hold a partial batch without emitting.
    always_comb begin
        w_idle_nxt = '0;
        if ((r_state == ST_RUN) && (r_acc != '0) && !w_emit_run)
            w_idle_nxt = r_idle + 1'b1;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            r_idle <= '0;
        else
            r_idle <= w_idle_nxt;
    end
`else
    assign w_flush = 1'b0;
`endif

    assign w_emit_run = (w_sum >= BATCH_V) || w_flush;

    always_comb begin
        w_state_nxt   = r_state;
        w_acc_nxt     = r_acc;
        w_step_nxt    = '0;
        w_exit_nxt    = r_exit;
        w_dropped_nxt = r_dropped;
        w_capture     = 1'b0;
        case (r_state)
            ST_RUN: begin
                if (w_emit_run) begin
                    w_step_nxt = w_e_run;
                    w_acc_nxt  = w_sum - {1'b0, w_e_run};
                end else begin
                    w_acc_nxt  = w_sum;
                end
                if (trap_valid) begin
                    w_capture   = 1'b1;
                    w_state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (commit_cnt != '0)
                    w_dropped_nxt = 1'b1;
                // Exit is only raised once the accumulator is empty, so it never coincides with a step.
                if (r_acc != '0) begin
                    w_step_nxt = w_e_drain;
                    w_acc_nxt  = r_acc - {1'b0, w_e_drain};
                end else begin
                    w_exit_nxt  = exit_code(r_trap_good, r_trap_code);
                    w_state_nxt = ST_EXITED;
                end
            end
            ST_EXITED: begin
                if (commit_cnt != '0)
                    w_dropped_nxt = 1'b1;
            end
            default: begin
                w_state_nxt = ST_RUN;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= ST_RUN;
            r_acc     <= '0;
            r_step    <= '0;
            r_exit    <= '0;
            r_dropped <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_acc     <= w_acc_nxt;
            r_step    <= w_step_nxt;
            r_exit    <= w_exit_nxt;
            r_dropped <= w_dropped_nxt;
        end
    end

    // Trap qualifiers are only consumed after capture, so they need no reset.
    always_ff @(posedge clock) begin
        if (w_capture) begin
            r_trap_good <= trap_good;
            r_trap_code <= trap_code;
        end
    end

    assign difftest_step = r_step;
    assign difftest_exit = r_exit;
    assign dropped       = r_dropped;

endmodule

// File: tb/tb_difftest_step_batcher.sv
// Randomized and directed bench for difftest_step_batcher against a behavioural model.
module tb_difftest_step_batcher;

    localparam int STEP_W   = 4;
    localparam int CNT_IN_W = 4;
    localparam int BATCH    = 10;
    localparam int TIMEOUT  = 8;
    localparam int MAXV     = (1 << STEP_W) - 1;
    localparam int MAXCNT   = (1 << CNT_IN_W) - 1;

    logic                clock = 1'b0;
    logic                reset_n = 1'b1;
    logic [CNT_IN_W-1:0] commit_cnt = '0;
    logic                trap_valid = 1'b0;
    logic                trap_good = 1'b0;
    logic [31:0]         trap_code = '0;
    logic [STEP_W-1:0]   difftest_step;
    logic [63:0]         difftest_exit;
    logic                dropped;

    int checks = 0;
    int failures = 0;

    // Behavioural model state
    int          m_acc;
    int          m_idle;
    bit          m_trapped;
    bit          m_exited;
    bit          m_good;
    logic [31:0] m_code;
    logic [STEP_W-1:0] m_step;
    logic [63:0] m_exit;
    bit          m_drop;

    difftest_step_batcher #(
        .STEP_W(STEP_W), .CNT_IN_W(CNT_IN_W), .BATCH(BATCH), .TIMEOUT(TIMEOUT)
    ) dut (
        .clock(clock), .reset_n(reset_n), .commit_cnt(commit_cnt),
        .trap_valid(trap_valid), .trap_good(trap_good), .trap_code(trap_code),
        .difftest_step(difftest_step), .difftest_exit(difftest_exit), .dropped(dropped)
    );

    always #5 clock = ~clock;

    task automatic model_reset();
        m_acc = 0; m_idle = 0; m_trapped = 0; m_exited = 0;
        m_good = 0; m_code = '0; m_step = '0; m_exit = '0; m_drop = 0;
    endtask

    task automatic model_cycle(input int cnt, input bit tv, input bit tg, input logic [31:0] tc);
        int sum, e, old_acc;
        bit emit, flush;
        m_step = '0;
        if (!m_trapped) begin
            old_acc = m_acc;
            sum = m_acc + cnt;
            flush = 0;
`ifdef DIFFTEST_STEP_TIMEOUT_EN
            flush = (m_idle == TIMEOUT - 1) && (sum != 0);
`endif
            emit = (sum >= BATCH) || flush;
            if (emit) begin
                e = (sum > MAXV) ? MAXV : sum;
                m_step = STEP_W'(e);
                m_acc = sum - e;
            end else begin
                m_acc = sum;
            end
            m_idle = (old_acc != 0 && !emit) ? m_idle + 1 : 0;
            if (tv) begin
                m_trapped = 1; m_good = tg; m_code = tc;
            end
        end else if (!m_exited) begin
            m_idle = 0;
            if (cnt != 0) m_drop = 1;
            if (m_acc > 0) begin
                e = (m_acc > MAXV) ? MAXV : m_acc;
                m_step = STEP_W'(e);
                m_acc = m_acc - e;
            end else begin
                m_exit = m_good ? 64'hFFFF_FFFF_FFFF_FFFF :
                         (m_code == 32'h0 ? 64'd1 : {32'h0, m_code});
                m_exited = 1;
            end
        end else begin
            if (cnt != 0) m_drop = 1;
        end
    endtask

    task automatic drive_cycle(input int cnt, input bit tv, input bit tg, input logic [31:0] tc);
        commit_cnt = CNT_IN_W'(cnt);
        trap_valid = tv;
        trap_good  = tg;
        trap_code  = tc;
        @(posedge clock);
        #1;
        model_cycle(cnt, tv, tg, tc);
        trap_valid = 1'b0;
        commit_cnt = '0;
    endtask

    task automatic apply_reset();
        commit_cnt = '0;
        trap_valid = 1'b0;
        reset_n = 1'b0;
        #1;
        model_reset();
        @(posedge clock);
        #1;
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        #2;
        reset_n = 1'b0;
        #1;
        model_reset();
        if (difftest_step !== 4'd0) begin failures++; $display("FAIL reset_async_step got=%0d exp=0", difftest_step); end
        checks++;
        if (difftest_exit !== 64'd0) begin failures++; $display("FAIL reset_async_exit got=%h exp=0", difftest_exit); end
        checks++;
        if (dropped !== 1'b0) begin failures++; $display("FAIL reset_async_dropped got=%b exp=0", dropped); end
        checks++;
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        #2;
        if ({difftest_step, difftest_exit, dropped} !== '0) begin
            failures++;
            $display("FAIL reset_release_outputs got step=%0d exit=%h dropped=%b exp all 0", difftest_step, difftest_exit, dropped);
        end
        checks++;
        drive_cycle(0, 0, 0, 0);
        if (difftest_step !== 4'd0) begin failures++; $display("FAIL reset_first_step got=%0d exp=0", difftest_step); end
        checks++;
    endtask

    task automatic test_threshold();
        int cnts[5] = '{3, 3, 3, 1, 0};
        int exps[5] = '{0, 0, 0, 10, 0};
        apply_reset();
        for (int i = 0; i < 5; i++) begin
            drive_cycle(cnts[i], 0, 0, 0);
            if (difftest_step !== STEP_W'(exps[i])) begin
                failures++;
                $display("FAIL threshold_step[%0d] got=%0d exp=%0d", i, difftest_step, exps[i]);
            end
            checks++;
        end
        if (difftest_exit !== 64'd0) begin failures++; $display("FAIL threshold_exit got=%h exp=0", difftest_exit); end
        checks++;
    endtask

    task automatic test_saturation();
        int cnts[5] = '{9, 15, 15, 0, 1};
        int exps[5] = '{0, 15, 15, 0, 10};
        apply_reset();
        for (int i = 0; i < 5; i++) begin
            drive_cycle(cnts[i], 0, 0, 0);
            if (difftest_step !== STEP_W'(exps[i])) begin
                failures++;
                $display("FAIL saturation_step[%0d] got=%0d exp=%0d", i, difftest_step, exps[i]);
            end
            checks++;
        end
    endtask

    task automatic test_good_trap();
        int          cnts[6]  = '{5, 3, 0, 0, 4, 0};
        bit          tvs[6]   = '{0, 1, 0, 0, 0, 1};
        int          exps[6]  = '{0, 0, 8, 0, 0, 0};
        logic [63:0] expx[6]  = '{64'd0, 64'd0, 64'd0, '1, '1, '1};
        bit          expd[6]  = '{0, 0, 0, 0, 1, 1};
        apply_reset();
        for (int i = 0; i < 6; i++) begin
            drive_cycle(cnts[i], tvs[i], (i == 1) ? 1'b1 : 1'b0, 32'h0000_0055);
            if (difftest_step !== STEP_W'(exps[i])) begin
                failures++;
                $display("FAIL good_trap_step[%0d] got=%0d exp=%0d", i, difftest_step, exps[i]);
            end
            checks++;
            if (difftest_exit !== expx[i]) begin
                failures++;
                $display("FAIL good_trap_exit[%0d] got=%h exp=%h", i, difftest_exit, expx[i]);
            end
            checks++;
            if (dropped !== expd[i]) begin
                failures++;
                $display("FAIL good_trap_dropped[%0d] got=%b exp=%b", i, dropped, expd[i]);
            end
            checks++;
        end
    endtask

    task automatic test_bad_trap();
        apply_reset();
        drive_cycle(0, 1, 0, 32'h0);
        if (difftest_exit !== 64'd0) begin failures++; $display("FAIL bad_trap_exit_early got=%h exp=0", difftest_exit); end
        checks++;
        drive_cycle(0, 0, 0, 0);
        if (difftest_exit !== 64'd1) begin failures++; $display("FAIL bad_trap_code0_exit got=%h exp=1", difftest_exit); end
        checks++;
        drive_cycle(2, 0, 0, 0);
        if (dropped !== 1'b1) begin failures++; $display("FAIL bad_trap_dropped got=%b exp=1", dropped); end
        checks++;
        if (difftest_step !== 4'd0) begin failures++; $display("FAIL bad_trap_step got=%0d exp=0", difftest_step); end
        checks++;
        drive_cycle(0, 1, 1, 0);
        drive_cycle(0, 0, 0, 0);
        if (difftest_exit !== 64'd1) begin failures++; $display("FAIL bad_trap_second_trap got=%h exp=1", difftest_exit); end
        checks++;
        apply_reset();
        drive_cycle(0, 1, 0, 32'hDEAD_BEEF);
        drive_cycle(5, 1, 1, 32'h1);
        if (difftest_exit !== 64'h0000_0000_DEAD_BEEF) begin
            failures++;
            $display("FAIL bad_trap_code_exit got=%h exp=00000000deadbeef", difftest_exit);
        end
        checks++;
    endtask

    task automatic test_reset_mid_drain();
        apply_reset();
        drive_cycle(7, 0, 0, 0);
        drive_cycle(0, 1, 1, 0);
        reset_n = 1'b0;
        #1;
        model_reset();
        if ({difftest_step, difftest_exit, dropped} !== '0) begin
            failures++;
            $display("FAIL mid_drain_reset got step=%0d exit=%h dropped=%b exp all 0", difftest_step, difftest_exit, dropped);
        end
        checks++;
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive_cycle(0, 0, 0, 0);
            if (difftest_step !== 4'd0 || difftest_exit !== 64'd0) begin
                failures++;
                $display("FAIL mid_drain_quiet[%0d] got step=%0d exit=%h exp 0/0", i, difftest_step, difftest_exit);
            end
            checks++;
        end
        drive_cycle(10, 0, 0, 0);
        if (difftest_step !== 4'd10) begin failures++; $display("FAIL mid_drain_resume got=%0d exp=10", difftest_step); end
        checks++;
    endtask

    task automatic test_timeout();
        logic [STEP_W-1:0] exp_s;
        apply_reset();
        drive_cycle(1, 0, 0, 0);
        for (int k = 1; k <= TIMEOUT + 3; k++) begin
            drive_cycle(0, 0, 0, 0);
`ifdef DIFFTEST_STEP_TIMEOUT_EN
            exp_s = (k == TIMEOUT) ? 4'd1 : 4'd0;
`else
            exp_s = 4'd0;
`endif
            if (difftest_step !== exp_s) begin
                failures++;
                $display("FAIL timeout_step[%0d] got=%0d exp=%0d", k, difftest_step, exp_s);
            end
            checks++;
        end
    endtask

    task automatic test_random();
        int exit_wait = 0;
        for (int i = 0; i < 800; i++) begin
            int          cnt;
            bit          tv, tg;
            logic [31:0] tc;
            if ($urandom_range(0, 99) == 0 || exit_wait > 3) begin
                apply_reset();
                exit_wait = 0;
                if ({difftest_step, difftest_exit, dropped} !== '0) begin
                    failures++;
                    $display("FAIL rand_reset[%0d] got step=%0d exit=%h dropped=%b exp all 0", i, difftest_step, difftest_exit, dropped);
                end
                checks++;
            end
            cnt = ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(1, MAXCNT));
            tv  = ($urandom_range(0, 24) == 0);
            tg  = 1'($urandom_range(0, 1));
            tc  = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
            drive_cycle(cnt, tv, tg, tc);
            if (difftest_step !== m_step) begin
                failures++;
                $display("FAIL rand_step[%0d] got=%0d exp=%0d", i, difftest_step, m_step);
            end
            checks++;
            if (difftest_exit !== m_exit) begin
                failures++;
                $display("FAIL rand_exit[%0d] got=%h exp=%h", i, difftest_exit, m_exit);
            end
            checks++;
            if (dropped !== m_drop) begin
                failures++;
                $display("FAIL rand_dropped[%0d] got=%b exp=%b", i, dropped, m_drop);
            end
            checks++;
            if (m_exited) exit_wait++;
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_threshold();
        test_saturation();
        test_good_trap();
        test_bad_trap();
        test_reset_mid_drain();
        test_timeout();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
